// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial-in/parallel-out frame receiver.
// Assembles N-bit MSB-first words from a bit-enabled serial stream with a start
// marker. Each completed word goes to a single-entry output buffer. The receiver
// also reports frame aborts (restart or gap timeout) and dropped words (overrun).
//
// Output handshake: o_valid high means o_data holds an unconsumed word. o_data
// stays stable while o_valid is high. A word transfers at any rising edge where
// o_valid && i_ready. o_valid never depends combinationally on i_ready. After
// consumption, o_data keeps the last word.
module sipo_frame_rx #(
    parameter int N       = 4,
    parameter int TIMEOUT = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_serial_in,
    input  logic         i_bit_en,
    input  logic         i_start,
    input  logic         i_ready,
    input  logic         i_clr_err,
    output logic [N-1:0] o_data,
    output logic         o_valid,
    output logic         o_frame_err,
    output logic         o_overrun,
    output logic         o_fsm_state
);

    localparam int CW = $clog2(N + 1);
    // With the timeout disabled, keep a 1-bit gap counter so the width is never zero.
    localparam int GW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(TIMEOUT);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    logic [N-1:0]    shift_reg;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   gap;

    logic            word_done;
    logic [N-1:0]    new_word;
    logic [GW-1:0]   gap_inc;
    logic            gap_expired;

    // Current FSM state, exposed for observation.
    assign o_fsm_state = (state == SHIFT);

    // Next-word assembly, completion detect and saturating gap increment.
    always_comb begin
        word_done   = (state == SHIFT) && i_bit_en && !i_start && (cnt == LAST_CNT);
        new_word    = {shift_reg[N-2:0], i_serial_in};
        gap_inc     = (gap == {GW{1'b1}}) ? gap : gap + 1'b1;
        gap_expired = (TIMEOUT > 0) && (gap_inc == GAP_MAX);
    end

    // Frame FSM, output buffer and error flags, all registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            cnt         <= '0;
            gap         <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    // Bits without a start marker are line noise between frames.
                    if (i_bit_en && i_start) begin
                        shift_reg <= {{(N-1){1'b0}}, i_serial_in};
                        cnt       <= CW'(1);
                        gap       <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (i_bit_en && i_start) begin
                        // A restart abandons the partial word and opens a new frame.
                        o_frame_err <= 1'b1;
                        shift_reg   <= {{(N-1){1'b0}}, i_serial_in};
                        cnt         <= CW'(1);
                        gap         <= '0;
                    end else if (i_bit_en) begin
                        shift_reg <= new_word;
                        gap       <= '0;
                        if (word_done) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (gap_expired) begin
                        o_frame_err <= 1'b1;
                        cnt         <= '0;
                        gap         <= '0;
                        state       <= IDLE;
                    end else begin
                        gap <= gap_inc;
                    end
                end
                default: state <= IDLE;
            endcase

            // Clear first so that a coincident new overrun below takes priority.
            if (i_clr_err) begin
                o_overrun <= 1'b0;
            end

            if (word_done) begin
                if (!o_valid || i_ready) begin
                    o_data  <= new_word;
                    o_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
